// File: rtl/stack_pkg.sv
// stack_pkg: shared count-width helper, op decode and default sizes for the return stack
package stack_pkg;
   localparam int DEF_DATA_W = 12;
   localparam int DEF_DEPTH  = 8;
   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_POP  = 2'b01;
   localparam logic [1:0] OP_PUSH = 2'b10;
   localparam logic [1:0] OP_REPL = 2'b11;
   function automatic int clog2_plus1(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/stack_ram.sv
// stack_ram: register file with one synchronous write port and one asynchronous read port
module stack_ram #(
   parameter int DATA_W = 12,
   parameter int DEPTH  = 8,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/return_stack.sv
// return_stack: parametrised LIFO for return addresses with peek, replace, optional wrap and sticky errors
module return_stack
   import stack_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int DEPTH        = DEF_DEPTH,
   parameter bit WRAP_ON_FULL = 1'b0,
   localparam int AW          = $clog2(DEPTH),
   localparam int CW          = clog2_plus1(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] push_data,
   output logic [DATA_W-1:0] pop_data,
   output logic              pop_valid,
   output logic [DATA_W-1:0] top_data,
   output logic              top_valid,
   output logic [CW-1:0]     count,
   output logic              full,
   output logic              empty,
   output logic              overflow,
   output logic              underflow,
   input  logic              clr_err
);
   logic [AW-1:0] sp, top, sp_inc, sp_n, waddr;
   logic [CW-1:0] count_n;
   logic [DATA_W-1:0] pop_data_n;
   logic we, pop_valid_n, ov_ev, un_ev;
   assign top    = (sp == '0) ? AW'(DEPTH - 1) : sp - 1'b1;
   assign sp_inc = (sp == AW'(DEPTH - 1)) ? '0 : sp + 1'b1;
   assign full      = count == CW'(DEPTH);
   assign empty     = count == '0;
   assign top_valid = !empty;
   stack_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk(clk), .we(we && !rst), .waddr(waddr), .wdata(push_data), .raddr(top), .rdata(top_data)
   );
   always_comb begin
      we = 1'b0;
      waddr = sp;
      sp_n = sp;
      count_n = count;
      pop_data_n = pop_data;
      pop_valid_n = 1'b0;
      ov_ev = 1'b0;
      un_ev = 1'b0;
      unique case ({push, pop})
         OP_PUSH: begin
            ov_ev = full;
            we = !full || WRAP_ON_FULL;
            sp_n = we ? sp_inc : sp;
            count_n = full ? count : count + 1'b1;
         end
         OP_POP: begin
            un_ev = empty;
            pop_valid_n = !empty;
            pop_data_n = empty ? pop_data : top_data;
            sp_n = empty ? sp : top;
            count_n = empty ? count : count - 1'b1;
         end
         OP_REPL: begin
            // an empty stack forwards the pushed value straight to the pop port
            pop_valid_n = 1'b1;
            pop_data_n = empty ? push_data : top_data;
            we = !empty;
            waddr = top;
         end
         default: ;
      endcase
   end
   always_ff @(posedge clk)
      if (rst) begin
         sp <= '0;
         count <= '0;
         pop_data <= '0;
         pop_valid <= 1'b0;
         overflow <= 1'b0;
         underflow <= 1'b0;
      end else begin
         sp <= sp_n;
         count <= count_n;
         pop_data <= pop_data_n;
         pop_valid <= pop_valid_n;
         overflow <= ov_ev || (overflow && !clr_err);
         underflow <= un_ev || (underflow && !clr_err);
      end
endmodule

// File: tb/tb_return_stack.sv
// tb_return_stack: drives both overflow modes with shared stimulus against queue models and a pop scoreboard
module tb_return_stack;
   typedef logic [11:0] q_t[$];
   logic clk = 1'b0, rst, push, pop, clr_err;
   logic [11:0] push_data;
   logic [11:0] pd [2], td [2];
   logic [3:0] cnt [2];
   logic pv [2], tv [2], fl [2], em [2], ov [2], un [2];
   q_t m0, m1, sb0, sb1;
   logic vexp [2], ovx [2], unx [2];
   logic [11:0] lastpd [2];
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 2; g++) begin : g_dut
      return_stack #(.DATA_W(12), .DEPTH(8), .WRAP_ON_FULL(g == 1)) u_dut (
         .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
         .pop_data(pd[g]), .pop_valid(pv[g]), .top_data(td[g]), .top_valid(tv[g]),
         .count(cnt[g]), .full(fl[g]), .empty(em[g]), .overflow(ov[g]), .underflow(un[g]),
         .clr_err(clr_err)
      );
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic model(input bit w, inout q_t m, inout logic o, inout logic u, output logic v, output logic [11:0] e);
      bit eo = 0, eu = 0;
      v = 0;
      e = '0;
      if (rst) begin
         m.delete();
         o = 0;
         u = 0;
         return;
      end
      if (push && pop) begin
         v = 1;
         if (m.size() > 0) begin
            e = m[$];
            m[$] = push_data;
         end else e = push_data;
      end else if (push) begin
         if (m.size() < 8) m.push_back(push_data);
         else begin
            eo = 1;
            if (w) begin
               void'(m.pop_front());
               m.push_back(push_data);
            end
         end
      end else if (pop) begin
         if (m.size() > 0) begin
            v = 1;
            e = m.pop_back();
         end else eu = 1;
      end
      o = (o && !clr_err) || eo;
      u = (u && !clr_err) || eu;
   endtask
   task automatic check(input int k);
      string pre = (k == 1) ? "w1." : "w0.";
      logic [11:0] e = '0;
      bit ok = 0;
      int n = (k == 1) ? m1.size() : m0.size();
      chk({pre, "pop_valid"}, 32'(pv[k]), 32'(vexp[k]));
      if (pv[k] === 1'b1) begin
         if (k == 0 && sb0.size() > 0) begin ok = 1; e = sb0.pop_front(); end
         if (k == 1 && sb1.size() > 0) begin ok = 1; e = sb1.pop_front(); end
         if (!ok) chk({pre, "unexpected_pop"}, 32'(1), 32'(0));
         else chk({pre, "pop_data"}, 32'(pd[k]), 32'(e));
      end
      chk({pre, "pop_data_hold"}, 32'(pd[k]), 32'(lastpd[k]));
      chk({pre, "count"}, 32'(cnt[k]), 32'(n));
      chk({pre, "full"}, 32'(fl[k]), 32'(n == 8));
      chk({pre, "empty"}, 32'(em[k]), 32'(n == 0));
      chk({pre, "top_valid"}, 32'(tv[k]), 32'(n != 0));
      chk({pre, "overflow"}, 32'(ov[k]), 32'(ovx[k]));
      chk({pre, "underflow"}, 32'(un[k]), 32'(unx[k]));
      if (n > 0) chk({pre, "top_data"}, 32'(td[k]), 32'((k == 1) ? m1[$] : m0[$]));
   endtask
   task automatic cyc(input logic p, input logic q, input logic [11:0] d, input logic c, input logic r);
      logic v;
      logic [11:0] e;
      push = p; pop = q; push_data = d; clr_err = c; rst = r;
      model(0, m0, ovx[0], unx[0], v, e);
      vexp[0] = v;
      if (r) begin lastpd[0] = '0; sb0.delete(); end
      if (v) begin sb0.push_back(e); lastpd[0] = e; end
      model(1, m1, ovx[1], unx[1], v, e);
      vexp[1] = v;
      if (r) begin lastpd[1] = '0; sb1.delete(); end
      if (v) begin sb1.push_back(e); lastpd[1] = e; end
      @(posedge clk);
      #1;
      check(0);
      check(1);
   endtask
   initial begin
      {rst, push, pop, clr_err} = 4'b1000;
      push_data = '0;
      lastpd[0] = '0; lastpd[1] = '0;
      #2;
      cyc(0, 0, 0, 0, 1);
      for (int i = 1; i <= 8; i++) cyc(1, 0, 12'(i), 0, 0);
      cyc(1, 0, 12'h009, 0, 0);
      cyc(1, 0, 12'h00A, 0, 0);
      cyc(0, 0, 0, 1, 0);
      for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 1, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(1, 0, 12'h111, 0, 0);
      cyc(1, 1, 12'h222, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(1, 1, 12'h333, 0, 0);
      for (int i = 0; i < 3; i++) cyc(1, 0, 12'h440 + 12'(i), 0, 0);
      cyc(1, 0, 12'h555, 0, 1);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      for (int i = 0; i < 400; i++)
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom),
             1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 63) == 0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/return_stack.md
Name: return_stack

Overview:
- Parametrised LIFO stack, the next generation of our 8x12 stack, for return addresses (jal/jr) in the MIPS core.
- Adds reset, configurable width and depth, and an optional circular overwrite-on-full mode.
- Adds a combinational top-of-stack peek, a same-cycle push+pop replace, and count/full/empty status.
- Error flags are sticky and clearable, so the controller and exception logic can poll them.

Parameters:
- DATA_W, 12: width of each entry in bits.
- DEPTH, 8: number of entries; any integer >= 2, not required to be a power of two.
- WRAP_ON_FULL, 0: behaviour when pushing to a full stack. 0 = push rejected. 1 = oldest entry overwritten (circular).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- push  input  1  push request.
- pop  input  1  pop request.
- push_data  input  DATA_W  value to push.
- pop_data  output  DATA_W  registered popped value.
- pop_valid  output  1  one-cycle pulse: pop_data was updated this cycle.
- top_data  output  DATA_W  combinational view of the current top entry.
- top_valid  output  1  equals !empty.
- count  output  $clog2(DEPTH+1)  number of valid entries.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky: a push arrived when full.
- underflow  output  1  sticky: a pop arrived when empty.
- clr_err  input  1  clears overflow and underflow.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - rst dominates push, pop and clr_err in the same cycle.
- Reset values:
  - count=0, sp=0, pop_data=0, pop_valid=0, overflow=0, underflow=0.
  - Storage array is not reset. Reset mid-sequence discards all entries.
- State:
  - sp is the write index, range 0..DEPTH-1, and wraps modulo DEPTH (explicit compare, no power-of-two assumption).
  - Top index = (sp-1) mod DEPTH.
  - count is tracked separately from sp.
- push only, not full: mem[sp]<=push_data; sp<=sp+1; count<=count+1.
- push only, full:
  - WRAP_ON_FULL=0: no write; sp and count unchanged; overflow<=1.
  - WRAP_ON_FULL=1: mem[sp]<=push_data (overwrites the oldest entry); sp<=sp+1 mod DEPTH; count stays DEPTH; overflow<=1 (flags the data loss).
- pop only, not empty: pop_data<=mem[top]; pop_valid<=1; sp<=sp-1 mod DEPTH; count<=count-1.
- pop only, empty: pop_data holds; pop_valid<=0; underflow<=1; nothing else changes.
- push and pop together, not empty (full or not):
  - pop_data<=mem[top]; mem[top]<=push_data; pop_valid<=1.
  - sp and count unchanged; no overflow.
- push and pop together, empty:
  - Bypass: pop_data<=push_data; pop_valid<=1.
  - count stays 0; no underflow; no write.
- Latency and timing:
  - pop_data and pop_valid are valid the cycle after the pop edge.
  - pop_valid is low in every cycle without a successful pop or bypass. pop_data holds its last value.
  - top_data = mem[top] combinationally. It is undefined (don't-care) when empty. It reflects a push from the next cycle onward.
  - full, empty and count are registered-state derived and change the cycle after the operation.
- Error flags:
  - clr_err clears both sticky flags.
  - If a new error event coincides with clr_err, the set wins.
  - Flags never self-clear.
- Width rules:
  - count width is $clog2(DEPTH+1), so DEPTH itself is representable.
  - No arithmetic on data.

Decomposition:
- Shared package stack_pkg holds:
  - the function clog2_plus1 for the count width;
  - localparam enumerating the four op cases {NOP, PUSH, POP, REPL} as a 2-bit {push,pop} decode;
  - default DATA_W=12 and DEPTH=8 constants for the core.
- One sub-module, stack_ram: DEPTH x DATA_W register file, one synchronous write port, one asynchronous read port (top index). It serves both top_data and pop_data capture.
- Pointer, count and flag logic stay in return_stack.

Test Plan:
- Reset then push 0x001..0x008 (DEPTH=8) -> count=8, full=1, top_data=0x008, overflow=0. Pop x8 -> pop_data sequence 0x008..0x001 with pop_valid pulse each cycle; empty=1 after.
- WRAP_ON_FULL=0: fill with 0x001..0x008, push 0x0AA -> overflow=1, count=8, top_data=0x008. Then clr_err -> overflow=0.
- WRAP_ON_FULL=1: fill with 0x001..0x008, push 0x009 then 0x00A -> count=8, overflow=1. Eight pops return 0x00A,0x009,0x008..0x003.
- Pop on empty -> underflow=1, pop_valid=0, pop_data unchanged. Same cycle clr_err=1 -> underflow still 1.
- Push 0x111, then push 0x222 with pop -> pop_data=0x111, count=1, top_data=0x222. On empty, push 0x333 with pop -> pop_data=0x333, pop_valid=1, count=0, underflow=0.
- Push 3 entries, assert rst together with push -> next cycle count=0, empty=1, pop_valid=0, flags 0. A following pop sets underflow.
